// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-beat memory port among NREQ engines.
// Optional exclusive-ownership locking is compiled in with `define MEMARB_LOCK_EN.
module mem_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          rq_req,
    input  logic [NREQ-1:0]          rq_write,
    input  logic [NREQ*MEM_AW-1:0]   rq_addr,
    input  logic [NREQ*MEM_DW-1:0]   rq_wdata,
`ifdef MEMARB_LOCK_EN
    input  logic [NREQ-1:0]          rq_lock,
`endif
    output logic [NREQ-1:0]          rq_gnt,
    output logic [NREQ-1:0]          rq_rdata_vld,
    output logic [MEM_DW-1:0]        rq_rdata,
    output logic                     mem_req,
    output logic                     mem_write,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic [MEM_DW-1:0]        mem_wdata,
    input  logic                     mem_rdata_vld,
    input  logic [MEM_DW-1:0]        mem_rdata,
    output logic                     err_spurious
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RD_WAIT = 1'b1;

    logic [0:0]      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [NREQ-1:0] req_eff;
    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [PW-1:0]   ptr_next;
    int              srch;

`ifdef MEMARB_LOCK_EN
    logic            lock_active;
    logic [PW-1:0]   lock_owner;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] k);
        logic [NREQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Search upward from the pointer, wrapping mod NREQ; first hit wins.
    always_comb begin
        req_eff = rq_req;
`ifdef MEMARB_LOCK_EN
        if (lock_active && rq_req[lock_owner])
            req_eff = rq_req & onehot(lock_owner);
`endif
        gnt_found = 1'b0;
        gnt_idx   = '0;
        srch      = 0;
        for (int i = 0; i < NREQ; i++) begin
            srch = (int'(ptr) + i) % NREQ;
            if (!gnt_found && req_eff[srch]) begin
                gnt_found = 1'b1;
                gnt_idx   = srch[PW-1:0];
            end
        end
    end

    assign gnt_any      = (state == IDLE) && gnt_found;
    assign rq_gnt       = gnt_any ? onehot(gnt_idx) : '0;
    assign ptr_next     = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign rq_rdata_vld = (state == RD_WAIT && mem_rdata_vld) ? onehot(owner) : '0;
    assign rq_rdata     = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            mem_req      <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err_spurious <= 1'b0;
        end else begin
            mem_req <= gnt_any;
            if (gnt_any) begin
                mem_write <= rq_write[gnt_idx];
                mem_addr  <= rq_addr[gnt_idx*MEM_AW +: MEM_AW];
                mem_wdata <= rq_wdata[gnt_idx*MEM_DW +: MEM_DW];
`ifdef MEMARB_LOCK_EN
                if (!rq_lock[gnt_idx])
                    ptr <= ptr_next;
`else
                ptr <= ptr_next;
`endif
                if (!rq_write[gnt_idx]) begin
                    state <= RD_WAIT;
                    owner <= gnt_idx;
                end
            end
            // Return arrives: back to IDLE, grants resume on the following cycle.
            if (state == RD_WAIT && mem_rdata_vld)
                state <= IDLE;
            if (state == IDLE && mem_rdata_vld)
                err_spurious <= 1'b1;
        end
    end

`ifdef MEMARB_LOCK_EN
    // A lock ends on an unlocked grant by the owner, or when the owner drops its request in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (gnt_any) begin
            lock_active <= rq_lock[gnt_idx];
            lock_owner  <= gnt_idx;
        end else if (state == IDLE && lock_active && !rq_req[lock_owner]) begin
            lock_active <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (NREQ=4, 16-bit address, 32-bit data).
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int NREQ   = 4;
    localparam int MEM_AW = 16;
    localparam int MEM_DW = 32;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        rq_req;
    logic [NREQ-1:0]        rq_write;
    logic [NREQ*MEM_AW-1:0] rq_addr;
    logic [NREQ*MEM_DW-1:0] rq_wdata;
    logic [NREQ-1:0]        rq_lock;
    logic [NREQ-1:0]        rq_gnt;
    logic [NREQ-1:0]        rq_rdata_vld;
    logic [MEM_DW-1:0]      rq_rdata;
    logic                   mem_req;
    logic                   mem_write;
    logic [MEM_AW-1:0]      mem_addr;
    logic [MEM_DW-1:0]      mem_wdata;
    logic                   mem_rdata_vld;
    logic [MEM_DW-1:0]      mem_rdata;
    logic                   err_spurious;

    int n_cmp;
    int n_bad;

    mem_port_arbiter #(.NREQ(NREQ), .MEM_AW(MEM_AW), .MEM_DW(MEM_DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rq_req       (rq_req),
        .rq_write     (rq_write),
        .rq_addr      (rq_addr),
        .rq_wdata     (rq_wdata),
`ifdef MEMARB_LOCK_EN
        .rq_lock      (rq_lock),
`endif
        .rq_gnt       (rq_gnt),
        .rq_rdata_vld (rq_rdata_vld),
        .rq_rdata     (rq_rdata),
        .mem_req      (mem_req),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata_vld(mem_rdata_vld),
        .mem_rdata    (mem_rdata),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns past the next rising edge; inputs are driven here, checks 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int k, input logic wr, input logic [15:0] a, input logic [31:0] d);
        rq_write[k]                   = wr;
        rq_addr[k*MEM_AW +: MEM_AW]   = a;
        rq_wdata[k*MEM_DW +: MEM_DW]  = d;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_err", 64'(err_spurious), 64'd0);
        #10 rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        rq_req = '0; rq_write = '0; rq_addr = '0; rq_wdata = '0; rq_lock = '0;
        mem_rdata_vld = 1'b0; mem_rdata = '0;

        // Reset values while rst_n is low.
        #3;
        chk("reset_mem_req", 64'(mem_req), 64'd0);
        chk("reset_gnt", 64'(rq_gnt), 64'd0);
        chk("reset_err", 64'(err_spurious), 64'd0);
        chk("reset_rdvld", 64'(rq_rdata_vld), 64'd0);
        chk("reset_addr", 64'(mem_addr), 64'd0);
        chk("reset_wdata", 64'(mem_wdata), 64'd0);
        #20 rst_n = 1'b1;

        // Idle with no requests for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            tick(); #2;
            chk("idle_mem_req", 64'(mem_req), 64'd0);
            chk("idle_gnt", 64'(rq_gnt), 64'd0);
            chk("idle_err", 64'(err_spurious), 64'd0);
        end

        // All four requesters write continuously: grants 0,1,2,3,0 one per cycle.
        for (int k = 0; k < NREQ; k++) set_rq(k, 1'b1, 16'h1000 + 16'(k), 32'hA0 + 32'(k));
        tick();
        rq_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("rr_gnt", 64'(rq_gnt), 64'(4'b0001 << (i % 4)));
            tick();
            chk("rr_mem_req", 64'(mem_req), 64'd1);
            chk("rr_mem_addr", 64'(mem_addr), 64'h1000 + 64'(i % 4));
            chk("rr_mem_wdata", 64'(mem_wdata), 64'hA0 + 64'(i % 4));
            chk("rr_mem_write", 64'(mem_write), 64'd1);
        end
        rq_req = '0;
        #2 chk("rr_gnt_off", 64'(rq_gnt), 64'd0);
        tick();
        chk("rr_mem_req_off", 64'(mem_req), 64'd0);
        chk("rr_addr_hold", 64'(mem_addr), 64'h1000);

        // Req1 reads 0x0040 (pointer is at 1); req2 writes while the read is outstanding.
        set_rq(1, 1'b0, 16'h0040, 32'h0);
        set_rq(2, 1'b1, 16'h2002, 32'h0000_0055);
        rq_req = 4'b0010;
        #2 chk("rd_gnt", 64'(rq_gnt), 64'b0010);
        tick();
        chk("rd_mem_req", 64'(mem_req), 64'd1);
        chk("rd_mem_write", 64'(mem_write), 64'd0);
        chk("rd_mem_addr", 64'(mem_addr), 64'h0040);
        rq_req = 4'b0100;
        #2 chk("rdwait_gnt0", 64'(rq_gnt), 64'd0);
        tick(); #2 chk("rdwait_gnt1", 64'(rq_gnt), 64'd0);
        chk("rdwait_mem_req", 64'(mem_req), 64'd0);
        tick(); #2 chk("rdwait_gnt2", 64'(rq_gnt), 64'd0);
        tick();
        mem_rdata_vld = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        #2;
        chk("rd_ret_vld", 64'(rq_rdata_vld), 64'b0010);
        chk("rd_ret_data", 64'(rq_rdata), 64'hDEAD_BEEF);
        chk("rd_ret_gnt", 64'(rq_gnt), 64'd0);
        tick();
        mem_rdata_vld = 1'b0;
        mem_rdata     = '0;
        #2;
        chk("after_vld_gnt", 64'(rq_gnt), 64'b0100);
        chk("after_vld_rdvld", 64'(rq_rdata_vld), 64'd0);
        tick();
        rq_req = '0;
        chk("wr2_mem_req", 64'(mem_req), 64'd1);
        chk("wr2_mem_addr", 64'(mem_addr), 64'h2002);
        chk("wr2_mem_wdata", 64'(mem_wdata), 64'h55);
        chk("wr2_err", 64'(err_spurious), 64'd0);

        // Spurious return in IDLE: not routed, sticky error.
        tick();
        mem_rdata_vld = 1'b1;
        mem_rdata     = 32'h1234_5678;
        #2 chk("spur_rdvld", 64'(rq_rdata_vld), 64'd0);
        tick();
        mem_rdata_vld = 1'b0;
        #2 chk("spur_err", 64'(err_spurious), 64'd1);
        for (int c = 0; c < 5; c++) tick();
        chk("spur_err_sticky", 64'(err_spurious), 64'd1);

        // Reset clears the error; then a read from req3 is cut off by reset.
        do_reset();
        chk("spur_err_cleared", 64'(err_spurious), 64'd0);
        tick();
        set_rq(3, 1'b0, 16'h0333, 32'h0);
        rq_req = 4'b1000;
        #2 chk("rd3_gnt", 64'(rq_gnt), 64'b1000);
        tick();
        rq_req = '0;
        chk("rd3_mem_req", 64'(mem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrd_rst_mem_req", 64'(mem_req), 64'd0);
        chk("midrd_rst_addr", 64'(mem_addr), 64'd0);
        chk("midrd_rst_err", 64'(err_spurious), 64'd0);
        #10 rst_n = 1'b1;
        tick();
        mem_rdata_vld = 1'b1;
        #2 chk("midrd_rdvld", 64'(rq_rdata_vld), 64'd0);
        tick();
        mem_rdata_vld = 1'b0;
        #2 chk("midrd_err", 64'(err_spurious), 64'd1);

`ifdef MEMARB_LOCK_EN
        // Req0 holds a lock for three writes while req1 waits.
        do_reset();
        tick();
        set_rq(0, 1'b1, 16'h0A00, 32'h1);
        set_rq(1, 1'b1, 16'h0B00, 32'h2);
        rq_req  = 4'b0011;
        rq_lock = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rq_lock = 4'b0000;
            #2 chk("lock_gnt0", 64'(rq_gnt), 64'b0001);
            tick();
            chk("lock_addr0", 64'(mem_addr), 64'h0A00);
        end
        rq_req = 4'b0010;
        #2 chk("lock_gnt1", 64'(rq_gnt), 64'b0010);
        tick();
        rq_req = '0;
        chk("lock_addr1", 64'(mem_addr), 64'h0B00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
